// File: rtl/pipeline_ex.sv
// Execute stage of the RV-32I pipeline: operand forwarding, single-cycle ALU/branch/jump
// and a three-cycle multiplier that back-pressures IF/ID while it runs.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | single-cycle ops flow through; a MUL latches operands here
// MUL1   | product computed from latched operands, stall still held
// MUL2   | product ready, stage advances and registers it
module pipeline_ex (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [4:0]  rd_i,
  input  logic [3:0]  alu_op_i,
  input  logic [31:0] imm_i,
  input  logic [5:0]  main_opcode_i,
  input  logic [31:0] pc_i,
  input  logic [3:0]  reg_forwarding_type_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [31:0] mem_load_data_i,
  output logic        valid_stall_o,
  output logic        valid_o,
  output logic [4:0]  rd_o,
  output logic [5:0]  main_opcode_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] store_data_o,
  output logic        branch_taken_o,
  output logic [31:0] branch_target_o
);

  typedef enum logic [1:0] {S_IDLE, S_MUL1, S_MUL2} mul_state_e;
  typedef enum logic [1:0] {SRC_REG, SRC_R1, SRC_R2, SRC_LD} src_e;

  mul_state_e state_r, state_nxt;
  src_e       src_a, src_b;

  logic [31:0] res_two_r;
  logic [31:0] op_a, op_b;
  logic [31:0] mul_a_r, mul_b_r, mul_res_r;
  logic [31:0] mul_sel;
  logic signed [32:0] mul_a_ext, mul_b_ext;
  logic signed [63:0] mul_full;

  logic        is_mul, is_bubble, stall;
  logic [31:0] ex_res, ex_target, addr_sum;
  logic        ex_taken, ex_valid, br_cond;
  logic [4:0]  ex_rd;

  function automatic logic [31:0] alu_calc(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [4:0]         sh;
    logic signed [31:0] sra_res;
    logic [31:0]        r;
    sh      = b[4:0];
    sra_res = $signed(a) >>> sh;
    r       = '0;
    case (op[2:0])
      3'b000: r = op[3] ? (a - b) : (a + b);
      3'b001: r = a << sh;
      3'b010: r = {31'b0, ($signed(a) < $signed(b))};
      3'b011: r = {31'b0, (a < b)};
      3'b100: r = a ^ b;
      3'b101: r = op[3] ? sra_res : (a >> sh);
      3'b110: r = a | b;
      3'b111: r = a & b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Forwarding code decode; unlisted codes read the register file.
  always_comb begin
    src_a = SRC_REG;
    src_b = SRC_REG;
    case (reg_forwarding_type_i)
      4'b0000: src_a = SRC_R1;
      4'b0001: src_b = SRC_R1;
      4'b0010: src_a = SRC_R2;
      4'b0011: src_b = SRC_R2;
      4'b0110: begin src_a = SRC_R1; src_b = SRC_R2; end
      4'b0111: begin src_a = SRC_R2; src_b = SRC_R1; end
      4'b1000: begin src_a = SRC_R1; src_b = SRC_R1; end
      4'b1001: begin src_a = SRC_R2; src_b = SRC_R2; end
      4'b0100: src_a = SRC_LD;
      4'b0101: src_b = SRC_LD;
      default: begin src_a = SRC_REG; src_b = SRC_REG; end
    endcase
  end

  always_comb begin
    case (src_a)
      SRC_R1:  op_a = alu_result_o;
      SRC_R2:  op_a = res_two_r;
      SRC_LD:  op_a = mem_load_data_i;
      default: op_a = rs1_data_i;
    endcase
    case (src_b)
      SRC_R1:  op_b = alu_result_o;
      SRC_R2:  op_b = res_two_r;
      SRC_LD:  op_b = mem_load_data_i;
      default: op_b = rs2_data_i;
    endcase
  end

  assign is_mul    = (main_opcode_i[5:2] == 4'b1111);
  assign is_bubble = (main_opcode_i == 6'b001111);

  always_comb begin
    state_nxt = state_r;
    stall     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (is_mul) begin
          state_nxt = S_MUL1;
          stall     = 1'b1;
        end
      end
      S_MUL1: begin
        state_nxt = S_MUL2;
        stall     = 1'b1;
      end
      S_MUL2:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Nothing may advance while reset is held, so the stall reads low then.
  assign valid_stall_o = stall & ~reset_i;

  // mm = 01 signed x signed, 10 signed x unsigned, 11 unsigned x unsigned, 00 low word.
  always_comb begin
    mul_a_ext = $signed({(main_opcode_i[1:0] == 2'b01 || main_opcode_i[1:0] == 2'b10)
                         & mul_a_r[31], mul_a_r});
    mul_b_ext = $signed({(main_opcode_i[1:0] == 2'b01) & mul_b_r[31], mul_b_r});
    mul_full  = mul_a_ext * mul_b_ext;
    mul_sel   = (main_opcode_i[1:0] == 2'b00) ? mul_full[31:0] : mul_full[63:32];
  end

  always_comb begin
    case (alu_op_i)
      4'b1001: br_cond = (op_a == op_b);
      4'b1010: br_cond = (op_a != op_b);
      4'b1011: br_cond = ($signed(op_a) <  $signed(op_b));
      4'b1100: br_cond = ($signed(op_a) >= $signed(op_b));
      4'b1110: br_cond = (op_a <  op_b);
      4'b1111: br_cond = (op_a >= op_b);
      default: br_cond = 1'b0;
    endcase
  end

  assign addr_sum = op_a + imm_i;

  always_comb begin
    ex_res    = '0;
    ex_taken  = 1'b0;
    ex_target = '0;
    ex_valid  = 1'b1;
    ex_rd     = rd_i;
    if (is_bubble) begin
      ex_valid = 1'b0;
      ex_rd    = '0;
    end else begin
      case (main_opcode_i[5:4])
        2'b00: ex_res = alu_calc(alu_op_i, op_a, op_b);
        2'b01: ex_res = alu_calc(alu_op_i, op_a, imm_i);
        default: begin
          case (main_opcode_i[5:3])
            3'b100, 3'b101: ex_res = addr_sum;
            3'b110: begin
              ex_taken  = br_cond;
              ex_target = pc_i + imm_i;
            end
            default: begin
              if (main_opcode_i[2]) begin
                ex_res = mul_res_r;
              end else begin
                case (main_opcode_i[1:0])
                  2'b00: ex_res = imm_i;
                  2'b01: ex_res = pc_i + imm_i;
                  2'b10: begin
                    ex_res    = pc_i + 32'd4;
                    ex_taken  = 1'b1;
                    ex_target = pc_i + imm_i;
                  end
                  default: begin
                    ex_res    = pc_i + 32'd4;
                    ex_taken  = 1'b1;
                    ex_target = addr_sum & ~32'd1;
                  end
                endcase
              end
            end
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r   <= S_IDLE;
      mul_a_r   <= '0;
      mul_b_r   <= '0;
      mul_res_r <= '0;
    end else begin
      state_r <= state_nxt;
      if (state_r == S_IDLE && is_mul) begin
        mul_a_r <= op_a;
        mul_b_r <= op_b;
      end
      if (state_r == S_MUL1) begin
        mul_res_r <= mul_sel;
      end
    end
  end

  // Stalled edges hold results and history but emit a bubble downstream.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      res_two_r       <= '0;
      valid_o         <= 1'b0;
      rd_o            <= '0;
      main_opcode_o   <= '0;
      alu_result_o    <= '0;
      store_data_o    <= '0;
      branch_taken_o  <= 1'b0;
      branch_target_o <= '0;
    end else if (stall) begin
      valid_o        <= 1'b0;
      branch_taken_o <= 1'b0;
    end else begin
      res_two_r       <= alu_result_o;
      valid_o         <= ex_valid;
      rd_o            <= ex_rd;
      main_opcode_o   <= main_opcode_i;
      alu_result_o    <= ex_res;
      store_data_o    <= op_b;
      branch_taken_o  <= ex_taken;
      branch_target_o <= ex_target;
    end
  end

endmodule

// File: tb/tb_pipeline_ex.sv
// Bench for pipeline_ex: directed vector table, reset/MUL corner sequences and
// randomized instructions checked against an arithmetic reference model.
module tb_pipeline_ex;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [4:0]  rd_i;
  logic [3:0]  alu_op_i;
  logic [31:0] imm_i;
  logic [5:0]  main_opcode_i;
  logic [31:0] pc_i;
  logic [3:0]  reg_forwarding_type_i;
  logic [31:0] rs1_data_i, rs2_data_i, mem_load_data_i;
  logic        valid_stall_o, valid_o, branch_taken_o;
  logic [4:0]  rd_o;
  logic [5:0]  main_opcode_o;
  logic [31:0] alu_result_o, store_data_o, branch_target_o;

  pipeline_ex dut (
    .clk_i(clk_i), .reset_i(reset_i), .rd_i(rd_i), .alu_op_i(alu_op_i), .imm_i(imm_i),
    .main_opcode_i(main_opcode_i), .pc_i(pc_i), .reg_forwarding_type_i(reg_forwarding_type_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .mem_load_data_i(mem_load_data_i),
    .valid_stall_o(valid_stall_o), .valid_o(valid_o), .rd_o(rd_o),
    .main_opcode_o(main_opcode_o), .alu_result_o(alu_result_o), .store_data_o(store_data_o),
    .branch_taken_o(branch_taken_o), .branch_target_o(branch_target_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [5:0]  opc;
    logic [3:0]  alu;
    logic [3:0]  fwd;
    logic [4:0]  rd;
    logic [31:0] rs1, rs2, imm, pc, ld;
  } instr_t;

  typedef struct {
    logic [31:0] res;
    logic        tk;
    logic [31:0] tgt;
    logic        vld;
  } exp_t;

  typedef struct {
    instr_t i;
    exp_t   e;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_r1 = '0;   // model of the one-back result
  logic [31:0] m_r2 = '0;   // model of the two-back result
  vec_t        tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic instr_t mk_i(input logic [5:0] opc, input logic [3:0] alu,
                                  input logic [3:0] fwd, input logic [4:0] rd,
                                  input logic [31:0] rs1, input logic [31:0] rs2,
                                  input logic [31:0] imm, input logic [31:0] pc,
                                  input logic [31:0] ld);
    instr_t i;
    i.opc = opc; i.alu = alu; i.fwd = fwd; i.rd = rd;
    i.rs1 = rs1; i.rs2 = rs2; i.imm = imm; i.pc = pc; i.ld = ld;
    return i;
  endfunction

  function automatic exp_t mk_e(input logic [31:0] res, input logic tk,
                                input logic [31:0] tgt, input logic vld);
    exp_t e;
    e.res = res; e.tk = tk; e.tgt = tgt; e.vld = vld;
    return e;
  endfunction

  function automatic void sel_ops(input instr_t i, output logic [31:0] a, output logic [31:0] b);
    a = i.rs1;
    b = i.rs2;
    case (i.fwd)
      4'b0000: a = m_r1;
      4'b0001: b = m_r1;
      4'b0010: a = m_r2;
      4'b0011: b = m_r2;
      4'b0110: begin a = m_r1; b = m_r2; end
      4'b0111: begin b = m_r1; a = m_r2; end
      4'b1000: begin a = m_r1; b = m_r1; end
      4'b1001: begin a = m_r2; b = m_r2; end
      4'b0100: a = i.ld;
      4'b0101: b = i.ld;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (op)
      4'b0000:          return a + b;
      4'b1000:          return a - b;
      4'b0001, 4'b1001: return a << b[4:0];
      4'b0010, 4'b1010: return (sa < sb) ? 32'd1 : 32'd0;
      4'b0011, 4'b1011: return (a < b) ? 32'd1 : 32'd0;
      4'b0100, 4'b1100: return a ^ b;
      4'b0101:          return a >> b[4:0];
      4'b1101:          return 32'(sa >>> b[4:0]);
      4'b0110, 4'b1110: return a | b;
      default:          return a & b;
    endcase
  endfunction

  function automatic logic br_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'b1001: return a == b;
      4'b1010: return a != b;
      4'b1011: return int'(a) < int'(b);
      4'b1100: return int'(a) >= int'(b);
      4'b1110: return a < b;
      4'b1111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t ref_exec(input instr_t i, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    e = mk_e(32'd0, 1'b0, 32'd0, 1'b1);
    if (i.opc == 6'b001111) begin
      e.vld = 1'b0;
    end else if (i.opc[5] == 1'b0) begin
      e.res = alu_ref(i.alu, a, i.opc[4] ? i.imm : b);
    end else begin
      case (i.opc[5:3])
        3'b100, 3'b101: e.res = a + i.imm;
        3'b110: begin
          e.tk  = br_ref(i.alu, a, b);
          e.tgt = i.pc + i.imm;
        end
        default: begin
          case (i.opc[2:0])
            3'd0: e.res = i.imm;
            3'd1: e.res = i.pc + i.imm;
            3'd2: begin e.res = i.pc + 4; e.tk = 1'b1; e.tgt = i.pc + i.imm; end
            3'd3: begin e.res = i.pc + 4; e.tk = 1'b1; e.tgt = (a + i.imm) & 32'hFFFF_FFFE; end
            3'd4: begin p = {32'd0, a} * {32'd0, b}; e.res = p[31:0]; end
            3'd5: begin p = 64'(longint'(int'(a)) * longint'(int'(b))); e.res = p[63:32]; end
            3'd6: begin p = 64'(longint'(int'(a)) * longint'({32'd0, b})); e.res = p[63:32]; end
            default: begin p = {32'd0, a} * {32'd0, b}; e.res = p[63:32]; end
          endcase
        end
      endcase
    end
    return e;
  endfunction

  task automatic drive(input instr_t i);
    main_opcode_i = i.opc; alu_op_i = i.alu; reg_forwarding_type_i = i.fwd; rd_i = i.rd;
    rs1_data_i = i.rs1; rs2_data_i = i.rs2; imm_i = i.imm; pc_i = i.pc; mem_load_data_i = i.ld;
  endtask

  // Called just after a falling edge; leaves the bench just after the next falling edge.
  task automatic apply(input instr_t i, input exp_t e, input string nm);
    logic [31:0] a, b, prev;
    logic        mul;
    sel_ops(i, a, b);
    drive(i);
    mul  = (i.opc[5:2] == 4'b1111);
    prev = m_r1;
    #1;
    chk({nm, " stall"}, 32'(valid_stall_o), 32'(mul));
    if (mul) begin
      @(posedge clk_i); #1;
      mem_load_data_i = $urandom;
      chk({nm, " mul1 stall"}, 32'(valid_stall_o), 32'd1);
      chk({nm, " mul1 valid"}, 32'(valid_o), 32'd0);
      chk({nm, " mul1 hold"}, alu_result_o, prev);
      @(posedge clk_i); #1;
      chk({nm, " mul2 stall"}, 32'(valid_stall_o), 32'd0);
      chk({nm, " mul2 valid"}, 32'(valid_o), 32'd0);
      chk({nm, " mul2 tk"}, 32'(branch_taken_o), 32'd0);
      chk({nm, " mul2 hold"}, alu_result_o, prev);
    end
    @(posedge clk_i); #1;
    chk({nm, " valid"}, 32'(valid_o), 32'(e.vld));
    chk({nm, " result"}, alu_result_o, e.res);
    chk({nm, " taken"}, 32'(branch_taken_o), 32'(e.tk));
    if (e.tk) chk({nm, " target"}, branch_target_o, e.tgt);
    if (e.vld) begin
      chk({nm, " rd"}, 32'(rd_o), 32'(i.rd));
      chk({nm, " opcode"}, 32'(main_opcode_o), 32'(i.opc));
    end else begin
      chk({nm, " rd"}, 32'(rd_o), 32'd0);
    end
    if (i.opc[5:3] == 3'b101) chk({nm, " store"}, store_data_o, b);
    m_r2 = m_r1;
    m_r1 = e.res;
    @(negedge clk_i);
  endtask

  function automatic instr_t rnd_instr();
    instr_t      i;
    int          k;
    logic [3:0]  codes [11];
    codes = '{4'b1111, 4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0110,
              4'b0111, 4'b1000, 4'b1001, 4'b0100, 4'b0101};
    k     = $urandom_range(0, 10);
    i.alu = 4'($urandom);
    i.rd  = 5'($urandom);
    i.rs1 = $urandom;
    i.rs2 = ($urandom_range(0, 3) == 0) ? i.rs1 : $urandom;
    i.imm = $urandom;
    i.pc  = $urandom;
    i.ld  = $urandom;
    i.fwd = ($urandom_range(0, 4) == 0) ? 4'($urandom) : codes[$urandom_range(0, 10)];
    case (k)
      0:       i.opc = {2'b00, 4'($urandom)};
      1:       i.opc = {2'b01, 4'($urandom)};
      2:       i.opc = {3'b100, 3'($urandom)};
      3:       i.opc = {3'b101, 3'($urandom)};
      4:       i.opc = {3'b110, 3'($urandom)};
      9:       i.opc = {4'b1111, 2'($urandom)};
      10:      i.opc = 6'b001111;
      default: i.opc = {4'b1110, 2'(k - 5)};
    endcase
    return i;
  endfunction

  initial begin
    instr_t      ri;
    logic [31:0] a, b;

    tbl.push_back('{mk_i(6'b010000, 4'b0000, 4'b1111, 5'd1, 32'd0, 32'd77, 32'd5, 32'd0, 32'd0),
                    mk_e(32'd5, 1'b0, 32'd0, 1'b1)});
    tbl.push_back('{mk_i(6'b000000, 4'b0000, 4'b1000, 5'd2, 32'h111, 32'h222, 32'd0, 32'd0, 32'd0),
                    mk_e(32'd10, 1'b0, 32'd0, 1'b1)});
    tbl.push_back('{mk_i(6'b000000, 4'b1000, 4'b0110, 5'd3, 32'h333, 32'h444, 32'd0, 32'd0, 32'd0),
                    mk_e(32'd5, 1'b0, 32'd0, 1'b1)});
    tbl.push_back('{mk_i(6'b100010, 4'b0000, 4'b1111, 5'd4, 32'h1000, 32'd0, 32'd4, 32'd0, 32'd0),
                    mk_e(32'h1004, 1'b0, 32'd0, 1'b1)});
    tbl.push_back('{mk_i(6'b000000, 4'b0000, 4'b0100, 5'd5, 32'hdead, 32'd3, 32'd0, 32'd0, 32'd7),
                    mk_e(32'd10, 1'b0, 32'd0, 1'b1)});
    tbl.push_back('{mk_i(6'b110000, 4'b1011, 4'b1111, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 32'd0),
                    mk_e(32'd0, 1'b1, 32'h120, 1'b1)});
    tbl.push_back('{mk_i(6'b111011, 4'b0000, 4'b1111, 5'd1, 32'h203, 32'd0, 32'd0, 32'h40, 32'd0),
                    mk_e(32'h44, 1'b1, 32'h202, 1'b1)});
    tbl.push_back('{mk_i(6'b111000, 4'b0000, 4'b1111, 5'd6, 32'd0, 32'd0, 32'h1234_5000, 32'd0, 32'd0),
                    mk_e(32'h1234_5000, 1'b0, 32'd0, 1'b1)});
    tbl.push_back('{mk_i(6'b111001, 4'b0000, 4'b1111, 5'd7, 32'd0, 32'd0, 32'h2000, 32'h1000, 32'd0),
                    mk_e(32'h3000, 1'b0, 32'd0, 1'b1)});
    tbl.push_back('{mk_i(6'b111010, 4'b0000, 4'b1111, 5'd1, 32'd0, 32'd0, 32'h100, 32'h80, 32'd0),
                    mk_e(32'h84, 1'b1, 32'h180, 1'b1)});
    tbl.push_back('{mk_i(6'b000000, 4'b1101, 4'b1111, 5'd8, 32'h8000_0000, 32'd4, 32'd0, 32'd0, 32'd0),
                    mk_e(32'hF800_0000, 1'b0, 32'd0, 1'b1)});
    tbl.push_back('{mk_i(6'b010000, 4'b0011, 4'b1111, 5'd9, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0),
                    mk_e(32'd1, 1'b0, 32'd0, 1'b1)});
    tbl.push_back('{mk_i(6'b001111, 4'b0000, 4'b1111, 5'd10, 32'd1, 32'd2, 32'd3, 32'd0, 32'd0),
                    mk_e(32'd0, 1'b0, 32'd0, 1'b0)});
    tbl.push_back('{mk_i(6'b000000, 4'b0000, 4'b0010, 5'd11, 32'h99, 32'd41, 32'd0, 32'd0, 32'd0),
                    mk_e(32'd42, 1'b0, 32'd0, 1'b1)});
    tbl.push_back('{mk_i(6'b000000, 4'b1000, 4'b0111, 5'd12, 32'h99, 32'h98, 32'd0, 32'd0, 32'd0),
                    mk_e(32'hFFFF_FFD6, 1'b0, 32'd0, 1'b1)});
    tbl.push_back('{mk_i(6'b000000, 4'b0000, 4'b1001, 5'd13, 32'h99, 32'h98, 32'd0, 32'd0, 32'd0),
                    mk_e(32'd84, 1'b0, 32'd0, 1'b1)});
    tbl.push_back('{mk_i(6'b110000, 4'b1001, 4'b0101, 5'd0, 32'd5, 32'd6, 32'hFFFF_FFF0, 32'h200, 32'd5),
                    mk_e(32'd0, 1'b1, 32'h1F0, 1'b1)});
    tbl.push_back('{mk_i(6'b110000, 4'b1100, 4'b1111, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h300, 32'd0),
                    mk_e(32'd0, 1'b0, 32'd0, 1'b1)});
    tbl.push_back('{mk_i(6'b101010, 4'b0000, 4'b1111, 5'd0, 32'h100, 32'hCAFE, 32'd8, 32'd0, 32'd0),
                    mk_e(32'h108, 1'b0, 32'd0, 1'b1)});
    tbl.push_back('{mk_i(6'b111101, 4'b0000, 4'b1111, 5'd14, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'd0),
                    mk_e(32'hFFFF_FFFF, 1'b0, 32'd0, 1'b1)});
    tbl.push_back('{mk_i(6'b000000, 4'b0000, 4'b0000, 5'd15, 32'h55, 32'd0, 32'd0, 32'd0, 32'd0),
                    mk_e(32'hFFFF_FFFF, 1'b0, 32'd0, 1'b1)});
    tbl.push_back('{mk_i(6'b111111, 4'b0000, 4'b0000, 5'd16, 32'h55, 32'd2, 32'd0, 32'd0, 32'd0),
                    mk_e(32'd1, 1'b0, 32'd0, 1'b1)});
    tbl.push_back('{mk_i(6'b111100, 4'b0000, 4'b1111, 5'd17, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 32'd0),
                    mk_e(32'hFFFF_FFFE, 1'b0, 32'd0, 1'b1)});
    tbl.push_back('{mk_i(6'b111110, 4'b0000, 4'b0100, 5'd18, 32'h55, 32'd3, 32'd0, 32'd0, 32'hFFFF_FFFE),
                    mk_e(32'hFFFF_FFFF, 1'b0, 32'd0, 1'b1)});

    reset_i = 1'b1;
    drive(mk_i(6'b001111, 4'd0, 4'b1111, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0));
    #1;
    chk("reset valid", 32'(valid_o), 32'd0);
    chk("reset result", alu_result_o, 32'd0);
    chk("reset rd", 32'(rd_o), 32'd0);
    chk("reset opcode", 32'(main_opcode_o), 32'd0);
    chk("reset taken", 32'(branch_taken_o), 32'd0);
    chk("reset target", branch_target_o, 32'd0);
    chk("reset store", store_data_o, 32'd0);
    chk("reset stall", 32'(valid_stall_o), 32'd0);
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;

    for (int t = 0; t < tbl.size(); t++)
      apply(tbl[t].i, tbl[t].e, $sformatf("vec%0d", t));

    // Reset landing in MUL1 must drop the multiply and clear all history.
    apply(mk_i(6'b111000, 4'd0, 4'b1111, 5'd3, 32'd0, 32'd0, 32'h5000, 32'd0, 32'd0),
          mk_e(32'h5000, 1'b0, 32'd0, 1'b1), "pre-rst lui");
    apply(mk_i(6'b111000, 4'd0, 4'b1111, 5'd4, 32'd0, 32'd0, 32'h6000, 32'd0, 32'd0),
          mk_e(32'h6000, 1'b0, 32'd0, 1'b1), "pre-rst lui2");
    drive(mk_i(6'b111100, 4'd0, 4'b1111, 5'd5, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0));
    @(posedge clk_i); #1;
    chk("rstmul mul1 stall", 32'(valid_stall_o), 32'd1);
    #2;
    reset_i = 1'b1;
    #1;
    chk("rstmul stall", 32'(valid_stall_o), 32'd0);
    chk("rstmul result", alu_result_o, 32'd0);
    chk("rstmul valid", 32'(valid_o), 32'd0);
    @(negedge clk_i);
    drive(mk_i(6'b001111, 4'd0, 4'b1111, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0));
    reset_i = 1'b0;
    m_r1 = '0;
    m_r2 = '0;
    apply(mk_i(6'b000000, 4'b0000, 4'b1001, 5'd6, 32'd9, 32'd9, 32'd0, 32'd0, 32'd0),
          mk_e(32'd0, 1'b0, 32'd0, 1'b1), "post-rst r2");
    apply(mk_i(6'b010000, 4'b0000, 4'b0000, 5'd7, 32'd9, 32'd9, 32'd12, 32'd0, 32'd0),
          mk_e(32'd12, 1'b0, 32'd0, 1'b1), "post-rst r1");

    for (int n = 0; n < 400; n++) begin
      ri = rnd_instr();
      sel_ops(ri, a, b);
      apply(ri, ref_exec(ri, a, b), $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ex.md
# pipeline_ex

Execute stage of the expanded RV-32I pipeline: consumes the registered decode bundle (operands, ALU opcode, immediate, main opcode, PC, forwarding type) and produces the registered EX result bundle for the memory stage. It resolves forwarding internally from its own one- and two-back result history, or from load data, using the decode stage's forwarding codes. It executes ALU, address, branch, jump and upper-immediate ops in one cycle and MUL-family ops in three cycles, back-pressuring IF/ID through `valid_stall_o`.

## Interface
- No parameters; XLEN fixed at 32.
- `clk_i` in 1: clock; all state updates on rising edge.
- `reset_i` in 1: reset, asynchronous, active-high.
- `rd_i`, `alu_op_i` [3:0], `imm_i` [31:0], `main_opcode_i` [5:0], `pc_i` [31:0], `reg_forwarding_type_i` [3:0] in: decode bundle (`rd_i` 5 bits).
- `rs1_data_i`, `rs2_data_i` in 32: register-file read data for the instruction in the decode bundle.
- `mem_load_data_i` in 32: load data from the memory stage, valid in the cycle a MEM_ONE code is presented.
- `valid_stall_o` out 1: holds IF/ID (combinational).
- `valid_o` out 1: EX output bundle holds a real instruction.
- `rd_o` [4:0], `main_opcode_o` [5:0], `alu_result_o` [31:0], `store_data_o` [31:0] out: registered result bundle.
- `branch_taken_o` out 1, `branch_target_o` out 32: registered control-flow resolution.

## Operation
- Operand A sources: `rs1_data_i` (default), R1 = `alu_result_o` (one back), R2 = history register `res_two_r` (two back), or `mem_load_data_i`. Operand B uses the same sources with `rs2_data_i` as the default.
- Forwarding codes:
  - 1111: none.
  - 0000: A←R1.
  - 0001: B←R1.
  - 0010: A←R2.
  - 0011: B←R2.
  - 0110: A←R1, B←R2.
  - 0111: B←R1, A←R2.
  - 1000: A←R1, B←R1.
  - 1001: A←R2, B←R2.
  - 0100: A←load data.
  - 0101: B←load data.
  - Any other code: none.
- Main opcode 00_aaaa (register-register ALU): A op B. Main opcode 01_aaaa (register-immediate ALU): A op imm.
  - `alu_op` encodings: 0000 add, 1000 sub, x001 sll, x010 slt, x011 sltu, x100 xor, 0101 srl, 1101 sra, x110 or, x111 and.
  - Shift amount is the low 5 bits of the second operand.
- 100fff load, 101fff store: result = A+imm. For stores, `store_data_o` = B; otherwise `store_data_o` = B as well (don't-care downstream).
- 110fff branch: `alu_op` 1001 beq, 1010 bne, 1011 blt, 1100 bge, 1110 bltu, 1111 bgeu.
  - Taken: target = pc+imm.
  - Result = 0.
- 111000 LUI: result = imm.
- 111001 AUIPC: result = pc+imm.
- 111010 JAL: result = pc+4, taken, target = pc+imm.
- 111011 JALR: result = pc+4, taken, target = (A+imm) & ~1.
- 1111mm MUL: 00 mul (low 32 bits of the product), 01 mulh (signed×signed, high 32 bits), 10 mulhsu (signed×unsigned, high 32 bits), 11 mulhu (unsigned×unsigned, high 32 bits).
- 001111 (illegal/bubble): `valid_o`=0, result 0, `rd_o`=0, not taken.
- All arithmetic is modulo 2^32; `branch_taken_o`=0 for non-control-flow ops.
- MUL FSM:
  - IDLE → MUL1 when a MUL opcode is presented; A/B are latched with forwarding applied.
  - MUL1 → MUL2 unconditionally.
  - MUL2 → IDLE, registering the product.
  - `valid_stall_o` = (IDLE && MUL opcode presented) || MUL1.
- Advance rule: on every edge where `valid_stall_o`=0, `res_two_r`←`alu_result_o` and the bundle registers load the new values. This includes bubbles, so the history matches the decode stage's two-back tracking.
- On stalled edges, result registers and `res_two_r` hold, while `valid_o`←0 and `branch_taken_o`←0 so that downstream sees a bubble.

## Timing
- Reset (async): all outputs 0, `res_two_r`=0, FSM IDLE. `main_opcode_o`=0 with `rd_o`=0 is harmless.
- Single-cycle ops: bundle at cycle N, result registered at edge N→N+1.
- MUL: presented in cycle N, stall high in N and N+1, result registered at edge N+2→N+3. Decode inputs are held stable by upstream throughout.
  - Output registers keep the pre-MUL result with `valid_o`=0 during N+1..N+2.
- An instruction following a MUL that forwards R1 receives the product.
- Reset asserted mid-MUL: FSM returns to IDLE immediately and the partial product is discarded.
- Back-to-back MULs: MUL2→IDLE, then the next MUL restarts the sequence. There is no overlap; each MUL stalls two cycles.

## Test plan
- Reset: assert `reset_i` between edges → all outputs 0 immediately, `valid_stall_o`=0.
- Forwarding: addi x1,x0,5 then add x2,x1,x1 (code 1000) → results 5 then 10. Third instruction sub x3,x2,x1 (code 0110) → 5.
- Load-use: load presented, then add with code 0100, `mem_load_data_i`=0x7, `rs2_data_i`=3 → 10.
- MUL: mulh A=0xFFFFFFFF, B=2 → `valid_stall_o` high 2 cycles, then result 0xFFFFFFFF. A following add using R1 gets 0xFFFFFFFF.
- Branch/jump: blt A=-1, B=1, pc=0x100, imm=0x20 → taken, target 0x120. JALR A=0x203, imm=0 → target 0x202, result pc+4.
- Reset mid-MUL: assert reset during MUL1 → IDLE, `valid_stall_o`=0, `alu_result_o`=0.
